// File: rtl/vending_pkg.sv
// Shared vending definitions: coin denominations, their values and the
// change-dispenser state encoding.
package vending_pkg;

  localparam int NUM_DENOM = 6;

  localparam logic [2:0] DENOM_500 = 3'd0;
  localparam logic [2:0] DENOM_100 = 3'd1;
  localparam logic [2:0] DENOM_25  = 3'd2;
  localparam logic [2:0] DENOM_10  = 3'd3;
  localparam logic [2:0] DENOM_5   = 3'd4;
  localparam logic [2:0] DENOM_1   = 3'd5;

  // Ordered highest value first so a lower index always means a bigger coin
  localparam logic [15:0] COIN_VALUE [NUM_DENOM] = '{
    16'd500, 16'd100, 16'd25, 16'd10, 16'd5, 16'd1
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_EJECT  = 2'd2,
    ST_DONE   = 2'd3
  } disp_state_t;

  function automatic logic [15:0] coin_value(input logic [2:0] idx);
    if (idx < 3'(NUM_DENOM)) return COIN_VALUE[idx];
    return 16'd0;
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Request, coin-hopper, refill and status signals of the change dispenser.
// master = upstream controller/hopper side, slave = the dispenser.
interface change_dispenser_if #(
  parameter int INV_W = 8
);
  import vending_pkg::*;

  logic                 I_REQ_VALID;
  logic [15:0]          I_AMOUNT;
  logic                 O_REQ_READY;
  logic                 O_COIN_VALID;
  logic [2:0]           O_COIN_SEL;
  logic                 I_COIN_ACK;
  logic                 I_REFILL_VALID;
  logic [2:0]           I_REFILL_SEL;
  logic [INV_W-1:0]     I_REFILL_CNT;
  logic                 O_DONE;
  logic                 O_SHORT;
  logic [15:0]          O_PAID;
  logic [15:0]          O_REMAIN;
  logic [NUM_DENOM-1:0] O_INV_EMPTY;

  modport master (
    output I_REQ_VALID, I_AMOUNT, I_COIN_ACK,
    output I_REFILL_VALID, I_REFILL_SEL, I_REFILL_CNT,
    input  O_REQ_READY, O_COIN_VALID, O_COIN_SEL,
    input  O_DONE, O_SHORT, O_PAID, O_REMAIN, O_INV_EMPTY
  );

  modport slave (
    input  I_REQ_VALID, I_AMOUNT, I_COIN_ACK,
    input  I_REFILL_VALID, I_REFILL_SEL, I_REFILL_CNT,
    output O_REQ_READY, O_COIN_VALID, O_COIN_SEL,
    output O_DONE, O_SHORT, O_PAID, O_REMAIN, O_INV_EMPTY
  );

endinterface

// File: rtl/change_dispenser_coin_picker.sv
// Greedy coin choice: largest-value denomination that still fits the
// remainder and has at least one coin in stock.
module coin_picker
  import vending_pkg::*;
(
  input  logic [15:0]          i_remain,
  input  logic [NUM_DENOM-1:0] i_avail,
  output logic                 o_found,
  output logic [2:0]           o_idx
);

  // Scan from the smallest coin upward so the lowest matching index wins
  always_comb begin
    o_found = 1'b0;
    o_idx   = 3'd0;
    for (int d = NUM_DENOM - 1; d >= 0; d--) begin
      if (i_avail[d] && (COIN_VALUE[d] <= i_remain)) begin
        o_found = 1'b1;
        o_idx   = 3'(d);
      end
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Pays a change amount one coin per hopper handshake, greedily from the
// largest stocked denomination, with per-denomination inventory tracking.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int INV_W    = 8,
  parameter int INV_INIT = 20
) (
  input  logic               I_CLK,
  input  logic               I_RESET,
  change_dispenser_if.slave  bus
);

  disp_state_t          r_state;
  disp_state_t          w_next;
  logic [15:0]          r_remain;
  logic [15:0]          r_paid;
  logic [2:0]           r_sel;
  logic [INV_W-1:0]     r_inv [NUM_DENOM];
  logic [NUM_DENOM-1:0] r_inv_empty;

  logic [NUM_DENOM-1:0] w_avail;
  logic                 w_found;
  logic [2:0]           w_pick;
  logic [15:0]          w_coin_val;
  logic [15:0]          w_remain_dec;
  logic                 w_ack;
  logic                 w_accept;
  logic                 w_refill;

  function automatic logic [INV_W-1:0] sat_add(input logic [INV_W-1:0] a,
                                               input logic [INV_W-1:0] b);
    logic [INV_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[INV_W] ? {INV_W{1'b1}} : s[INV_W-1:0];
  endfunction

  always_comb begin
    w_avail = '0;
    for (int d = 0; d < NUM_DENOM; d++) w_avail[d] = (r_inv[d] != '0);
  end

  coin_picker u_picker (
    .i_remain (r_remain),
    .i_avail  (w_avail),
    .o_found  (w_found),
    .o_idx    (w_pick)
  );

  assign w_coin_val   = coin_value(r_sel);
  assign w_remain_dec = r_remain - w_coin_val;
  assign w_ack        = (r_state == ST_EJECT) && bus.I_COIN_ACK;
  assign w_accept     = (r_state == ST_IDLE) && bus.I_REQ_VALID;
  // A refill competing with a request is dropped, as is any out-of-range index
  assign w_refill     = (r_state == ST_IDLE) && !bus.I_REQ_VALID &&
                        bus.I_REFILL_VALID && (bus.I_REFILL_SEL < 3'(NUM_DENOM));

  always_ff @(posedge I_CLK) begin
    if (I_RESET) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (bus.I_REQ_VALID) w_next = (bus.I_AMOUNT == 16'd0) ? ST_DONE : ST_SELECT;
      ST_SELECT: w_next = w_found ? ST_EJECT : ST_DONE;
      ST_EJECT:  if (bus.I_COIN_ACK) w_next = (w_remain_dec == 16'd0) ? ST_DONE : ST_SELECT;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.O_REQ_READY  = (r_state == ST_IDLE);
    bus.O_COIN_VALID = (r_state == ST_EJECT);
    bus.O_COIN_SEL   = r_sel;
    bus.O_DONE       = (r_state == ST_DONE);
    bus.O_SHORT      = (r_state == ST_DONE) && (r_remain != 16'd0);
    bus.O_PAID       = r_paid;
    bus.O_REMAIN     = r_remain;
    bus.O_INV_EMPTY  = r_inv_empty;
  end

  // Payment bookkeeping: paid + remain always equals the accepted amount
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      r_remain <= 16'd0;
      r_paid   <= 16'd0;
      r_sel    <= 3'd0;
    end else begin
      if (w_accept) begin
        r_remain <= bus.I_AMOUNT;
        r_paid   <= 16'd0;
      end
      if ((r_state == ST_SELECT) && w_found) r_sel <= w_pick;
      if (w_ack) begin
        r_remain <= w_remain_dec;
        r_paid   <= r_paid + w_coin_val;
      end
    end
  end

  // SELECT only picks stocked coins, so the decrement never wraps
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      for (int d = 0; d < NUM_DENOM; d++) r_inv[d] <= INV_W'(INV_INIT);
      r_inv_empty <= {NUM_DENOM{INV_INIT == 0}};
    end else begin
      for (int d = 0; d < NUM_DENOM; d++) begin
        if (w_ack && (r_sel == 3'(d)))
          r_inv[d] <= r_inv[d] - 1'b1;
        else if (w_refill && (bus.I_REFILL_SEL == 3'(d)))
          r_inv[d] <= sat_add(r_inv[d], bus.I_REFILL_CNT);
        r_inv_empty[d] <= (r_inv[d] == '0);
      end
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: two instances (stock 20 and stock 1)
// sharing one stimulus bus, selected by dsel.
module tb_change_dispenser;
  import vending_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        dsel = 1'b0;
  logic        req_valid = 1'b0;
  logic [15:0] amount = 16'd0;
  logic        coin_ack = 1'b0;
  logic        refill_valid = 1'b0;
  logic [2:0]  refill_sel = 3'd0;
  logic [7:0]  refill_cnt = 8'd0;

  change_dispenser_if #(.INV_W(8)) ifa ();
  change_dispenser_if #(.INV_W(8)) ifb ();

  assign ifa.I_REQ_VALID    = req_valid & ~dsel;
  assign ifb.I_REQ_VALID    = req_valid &  dsel;
  assign ifa.I_AMOUNT       = amount;
  assign ifb.I_AMOUNT       = amount;
  assign ifa.I_COIN_ACK     = coin_ack & ~dsel;
  assign ifb.I_COIN_ACK     = coin_ack &  dsel;
  assign ifa.I_REFILL_VALID = refill_valid & ~dsel;
  assign ifb.I_REFILL_VALID = refill_valid &  dsel;
  assign ifa.I_REFILL_SEL   = refill_sel;
  assign ifb.I_REFILL_SEL   = refill_sel;
  assign ifa.I_REFILL_CNT   = refill_cnt;
  assign ifb.I_REFILL_CNT   = refill_cnt;

  change_dispenser #(.INV_W(8), .INV_INIT(20)) u_a (.I_CLK(clk), .I_RESET(rst), .bus(ifa.slave));
  change_dispenser #(.INV_W(8), .INV_INIT(1))  u_b (.I_CLK(clk), .I_RESET(rst), .bus(ifb.slave));

  logic        o_ready, o_coin_valid, o_done, o_short;
  logic [2:0]  o_sel;
  logic [15:0] o_paid, o_remain;
  logic [5:0]  o_inv_empty;
  assign o_ready      = dsel ? ifb.O_REQ_READY  : ifa.O_REQ_READY;
  assign o_coin_valid = dsel ? ifb.O_COIN_VALID : ifa.O_COIN_VALID;
  assign o_done       = dsel ? ifb.O_DONE       : ifa.O_DONE;
  assign o_short      = dsel ? ifb.O_SHORT      : ifa.O_SHORT;
  assign o_sel        = dsel ? ifb.O_COIN_SEL   : ifa.O_COIN_SEL;
  assign o_paid       = dsel ? ifb.O_PAID       : ifa.O_PAID;
  assign o_remain     = dsel ? ifb.O_REMAIN     : ifa.O_REMAIN;
  assign o_inv_empty  = dsel ? ifb.O_INV_EMPTY  : ifa.O_INV_EMPTY;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // seq holds coin k in bits [3k+:3]; octal literals read last coin first
  typedef struct {
    logic        ds;
    logic [15:0] amount;
    int          nc;
    logic [47:0] seq;
    logic [15:0] paid;
    logic [15:0] remain;
    logic        short_;
    int          fn;
    int          dn;
  } vec_t;

  vec_t vecs [5];

  task automatic run_req(input logic ds, input logic [15:0] amt,
                         output int nc, output logic [47:0] sq,
                         output logic [15:0] pd, output logic [15:0] rm,
                         output logic sh, output int fn, output int dn,
                         output bit gap_ok, output bit done_ok);
    int last;
    nc = 0; sq = '0; pd = '0; rm = '0; sh = 1'b0;
    fn = -1; dn = -1; gap_ok = 1'b1; done_ok = 1'b0; last = -1;
    dsel = ds;
    @(negedge clk);
    for (int i = 0; i < 20 && !o_ready; i++) @(negedge clk);
    req_valid = 1'b1;
    amount    = amt;
    @(negedge clk);
    req_valid = 1'b0;
    for (int n = 0; n < 200; n++) begin
      coin_ack = 1'b0;
      if (o_done) begin
        pd = o_paid; rm = o_remain; sh = o_short;
        dn = n; done_ok = 1'b1;
        break;
      end
      if (o_coin_valid) begin
        if (nc < 16) sq[3*nc +: 3] = o_sel;
        if (nc == 0) fn = n;
        else if (n - last != 2) gap_ok = 1'b0;
        last = n;
        nc++;
        coin_ack = 1'b1;
      end
      @(negedge clk);
    end
    coin_ack = 1'b0;
  endtask

  task automatic do_refill(input logic ds, input logic [2:0] sel, input logic [7:0] cnt);
    dsel = ds;
    @(negedge clk);
    refill_valid = 1'b1; refill_sel = sel; refill_cnt = cnt;
    @(negedge clk);
    refill_valid = 1'b0;
  endtask

  int          nc, fn, dn;
  logic [47:0] sq;
  logic [15:0] pd, rm;
  logic        sh;
  bit          gap_ok, done_ok, bad;

  initial begin
    vecs[0] = '{1'b0, 16'd200,  2,  48'o11,         16'd200,  16'd0,   1'b0, 1, 4};
    vecs[1] = '{1'b0, 16'd141,  5,  48'o54321,      16'd141,  16'd0,   1'b0, 1, 10};
    vecs[2] = '{1'b0, 16'd1234, 10, 48'o5555421100, 16'd1234, 16'd0,   1'b0, 1, 20};
    vecs[3] = '{1'b0, 16'd0,    0,  48'o0,          16'd0,    16'd0,   1'b0, -1, 0};
    vecs[4] = '{1'b1, 16'd250,  5,  48'o54321,      16'd141,  16'd109, 1'b1, 1, 11};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready",     {47'd0, o_ready},      48'd1);
    chk("reset_coin_vld",  {47'd0, o_coin_valid}, 48'd0);
    chk("reset_done",      {47'd0, o_done},       48'd0);
    chk("reset_paid",      {32'd0, o_paid},       48'd0);
    chk("reset_inv_empty_a", {42'd0, o_inv_empty}, 48'd0);
    dsel = 1'b1;
    #1;
    chk("reset_inv_empty_b", {42'd0, o_inv_empty}, 48'd0);

    for (int v = 0; v < 5; v++) begin
      run_req(vecs[v].ds, vecs[v].amount, nc, sq, pd, rm, sh, fn, dn, gap_ok, done_ok);
      chk($sformatf("v%0d_done_seen", v), {47'd0, done_ok}, 48'd1);
      chk($sformatf("v%0d_ncoins", v), 48'(nc), 48'(vecs[v].nc));
      chk($sformatf("v%0d_seq", v), sq, vecs[v].seq);
      chk($sformatf("v%0d_paid", v), {32'd0, pd}, {32'd0, vecs[v].paid});
      chk($sformatf("v%0d_remain", v), {32'd0, rm}, {32'd0, vecs[v].remain});
      chk($sformatf("v%0d_short", v), {47'd0, sh}, {47'd0, vecs[v].short_});
      chk($sformatf("v%0d_done_lat", v), 48'(dn), 48'(vecs[v].dn));
      if (vecs[v].nc > 0) begin
        chk($sformatf("v%0d_first_lat", v), 48'(fn), 48'(vecs[v].fn));
        chk($sformatf("v%0d_ack_gap", v), {47'd0, gap_ok}, 48'd1);
      end
    end

    // Low-stock instance: only the 500 coin is left after paying 141 of 250
    chk("b_inv_empty_short", {42'd0, o_inv_empty}, {42'd0, 6'b111110});

    do_refill(1'b1, DENOM_100, 8'd2);
    run_req(1'b1, 16'd200, nc, sq, pd, rm, sh, fn, dn, gap_ok, done_ok);
    chk("b_refill_ncoins", 48'(nc), 48'd2);
    chk("b_refill_seq",    sq, 48'o11);
    chk("b_refill_short",  {47'd0, sh}, 48'd0);
    chk("b_refill_paid",   {32'd0, pd}, 48'd200);

    // Refill of the 1-cent coin pulsed while ejecting the last 500 coin
    dsel = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; amount = 16'd500;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("b_ej_valid", {47'd0, o_coin_valid}, 48'd1);
    chk("b_ej_sel",   {45'd0, o_sel}, {45'd0, DENOM_500});
    refill_valid = 1'b1; refill_sel = DENOM_1; refill_cnt = 8'd10;
    @(negedge clk);
    refill_valid = 1'b0;
    coin_ack = 1'b1;
    @(negedge clk);
    coin_ack = 1'b0;
    bad = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (o_done) begin bad = 1'b0; break; end
      @(negedge clk);
    end
    chk("b_ej_done_seen", {47'd0, ~bad}, 48'd1);
    chk("b_ej_short", {47'd0, o_short}, 48'd0);
    chk("b_ej_paid",  {32'd0, o_paid}, 48'd500);
    @(negedge clk);
    chk("b_inv_all_empty", {42'd0, o_inv_empty}, {42'd0, 6'b111111});
    run_req(1'b1, 16'd1, nc, sq, pd, rm, sh, fn, dn, gap_ok, done_ok);
    chk("b_nostock_ncoins", 48'(nc), 48'd0);
    chk("b_nostock_short",  {47'd0, sh}, 48'd1);
    chk("b_nostock_remain", {32'd0, rm}, 48'd1);
    chk("b_nostock_lat",    48'(dn), 48'd1);

    // Stalled hopper, then reset while the eject is pending
    dsel = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; amount = 16'd5;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (!o_coin_valid || o_sel != DENOM_5) bad = 1'b1;
      @(negedge clk);
    end
    chk("a_hold_stable", {47'd0, bad}, 48'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("a_rst_ready",    {47'd0, o_ready}, 48'd1);
    chk("a_rst_coin_vld", {47'd0, o_coin_valid}, 48'd0);
    chk("a_rst_sel",      {45'd0, o_sel}, 48'd0);
    chk("a_rst_remain",   {32'd0, o_remain}, 48'd0);
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (o_done) bad = 1'b1;
      @(negedge clk);
    end
    chk("a_rst_no_done", {47'd0, bad}, 48'd0);
    dsel = 1'b1;
    #1;
    chk("b_rst_inv_restored", {42'd0, o_inv_empty}, 48'd0);

    run_req(1'b0, 16'd0, nc, sq, pd, rm, sh, fn, dn, gap_ok, done_ok);
    chk("a_zero_done_seen", {47'd0, done_ok}, 48'd1);
    chk("a_zero_lat",    48'(dn), 48'd0);
    chk("a_zero_ncoins", 48'(nc), 48'd0);
    chk("a_zero_short",  {47'd0, sh}, 48'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
